// File: rtl/if_stage_pipelined_pkg.sv
// Shared types for the pipelined instruction-fetch stage: FSM states,
// default bubble word and the IF/ID payload layout.
package if_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } if_state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] instr;
  } ifid_t;

endpackage

// File: rtl/if_stage_pipelined_ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds a valid slot,
// otherwise a load request writes a fresh instruction.
module ifid_reg
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_WORD_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_pc_plus,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic [XLEN-1:0] instr
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] instr;
  } slot_t;

  slot_t q;

  // A stall only protects a slot that actually holds an instruction.
  always_ff @(posedge clock) begin
    if (reset) begin
      q.valid   <= 1'b0;
      q.pc      <= '0;
      q.pc_plus <= '0;
      q.instr   <= NOP_WORD;
    end else if (flush) begin
      q.valid <= 1'b0;
      q.instr <= NOP_WORD;
    end else if (!(stall && q.valid) && load) begin
      q.valid   <= 1'b1;
      q.pc      <= load_pc;
      q.pc_plus <= load_pc_plus;
      q.instr   <= load_instr;
    end
  end

  assign valid   = q.valid;
  assign pc      = q.pc;
  assign pc_plus = q.pc_plus;
  assign instr   = q.instr;

endmodule

// File: rtl/if_stage_pipelined.sv
// Instruction-fetch stage: PC, request/grant/response fetch FSM with a
// one-word skid buffer, redirect handling and the IF/ID register.
module if_stage_pipelined
  import if_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] NOP_WORD    = XLEN'(NOP_WORD_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus,
  output logic [XLEN-1:0] ifid_instr
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

  if_state_e       state, state_n;
  logic [XLEN-1:0] pc, pc_n, skid, skid_n;
  logic [XLEN-1:0] pc_inc, target, load_instr;
  logic            load, can_load;

  assign pc_inc    = pc + STEP;
  assign target    = redirect_pc & ALIGN_MASK;
  assign can_load  = (!stall || !ifid_valid) && !flush;
  assign imem_req  = (state == REQ) && !reset;
  assign imem_addr = pc;

  // A response that cannot enter IF/ID (stall, or flush without redirect)
  // parks in the skid buffer; a redirect discards whatever is in flight.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    skid_n     = skid;
    load       = 1'b0;
    load_instr = imem_rdata;
    case (state)
      REQ: begin
        if (imem_gnt) state_n = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            state_n = REQ;
          end else if (can_load) begin
            load    = 1'b1;
            pc_n    = pc_inc;
            state_n = REQ;
          end else begin
            skid_n  = imem_rdata;
            state_n = HOLD;
          end
        end else if (redirect_valid) begin
          state_n = DROP;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_n = REQ;
        end else if (can_load) begin
          load       = 1'b1;
          load_instr = skid;
          pc_n       = pc_inc;
          state_n    = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) state_n = REQ;
      end
      default: state_n = REQ;
    endcase
    if (redirect_valid) pc_n = target;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= REQ;
      pc    <= RESET_PC;
      skid  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      skid  <= skid_n;
    end
  end

  ifid_reg #(
    .XLEN     (XLEN),
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .stall        (stall),
    .load         (load),
    .load_pc      (pc),
    .load_pc_plus (pc_inc),
    .load_instr   (load_instr),
    .valid        (ifid_valid),
    .pc           (ifid_pc),
    .pc_plus      (ifid_pc_plus),
    .instr        (ifid_instr)
  );

endmodule

// File: tb/tb_if_stage_pipelined.sv
// Randomized bench for if_stage_pipelined: two instances (reset PC 0 and
// 0xFFFF_FFFC) share stimulus and are checked against a transaction-level model.
module tb_if_stage_pipelined;
  import if_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h2001_0005;
  localparam logic [31:0] W1  = 32'h2002_000A;

  logic        clock = 1'b0;
  logic        reset, stall, flush, redirect_valid, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;

  logic        a_req, a_valid, b_req, b_valid;
  logic [31:0] a_addr, a_pc, a_plus, a_instr;
  logic [31:0] b_addr, b_pc, b_plus, b_instr;

  always #5 clock = ~clock;

  if_stage_pipelined #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .INSTR_BYTES(4), .NOP_WORD(NOP)
  ) u_dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_valid(a_valid), .ifid_pc(a_pc), .ifid_pc_plus(a_plus), .ifid_instr(a_instr)
  );

  if_stage_pipelined #(
    .XLEN(32), .RESET_PC(32'hFFFF_FFFC), .INSTR_BYTES(4), .NOP_WORD(NOP)
  ) u_wrap (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_valid(b_valid), .ifid_pc(b_pc), .ifid_pc_plus(b_plus), .ifid_instr(b_instr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a fetch is either idle (may request), in flight (maybe doomed),
  // or parked waiting for the slot; the two instances differ only in PC.
  bit          busy, doomed, parked, mem_pend;
  int          mem_dly, max_dly, loads, resps, phase;
  logic [31:0] parked_word;
  logic [31:0] m_pc   [2];
  logic [31:0] rst_pc [2];
  ifid_t       m_slot [2];
  bit          d1_done, d2_done;

  task automatic step_model();
    bit          can, ld;
    logic [31:0] word;
    if (reset) begin
      busy = 0; doomed = 0; parked = 0; mem_pend = 0; parked_word = '0;
      loads = 0; resps = 0;
      for (int k = 0; k < 2; k++) begin
        m_pc[k]   = rst_pc[k];
        m_slot[k] = '{valid: 1'b0, pc: '0, pc_plus: '0, instr: NOP};
      end
      return;
    end
    can  = !stall || !m_slot[0].valid;
    ld   = 0;
    word = imem_rdata;
    if (imem_rvalid) begin
      mem_pend = 0;
      resps++;
    end else if (mem_pend && mem_dly > 0) begin
      mem_dly--;
    end
    if (!busy && !parked) begin
      if (imem_gnt) begin
        busy = 1; doomed = redirect_valid;
        mem_pend = 1; mem_dly = $urandom_range(0, max_dly);
      end
    end else if (busy) begin
      if (imem_rvalid) begin
        busy = 0;
        if (!doomed && !redirect_valid) begin
          if (can && !flush) ld = 1;
          else begin parked = 1; parked_word = imem_rdata; end
        end
        doomed = 0;
      end else if (redirect_valid) begin
        doomed = 1;
      end
    end else begin
      if (redirect_valid) parked = 0;
      else if (can && !flush) begin ld = 1; word = parked_word; parked = 0; end
    end
    if (ld) loads++;
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        m_slot[k].valid = 1'b0;
        m_slot[k].instr = NOP;
      end else if (!(stall && m_slot[k].valid) && ld) begin
        m_slot[k] = '{valid: 1'b1, pc: m_pc[k], pc_plus: m_pc[k] + 32'd4, instr: word};
      end
      if (ld) m_pc[k] = m_pc[k] + 32'd4;
      if (redirect_valid) m_pc[k] = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic check_all();
    logic exp_req;
    exp_req = !busy && !parked && !reset;
    check_val("a_req",   {31'd0, a_req},   {31'd0, exp_req});
    check_val("a_addr",  a_addr,  m_pc[0]);
    check_val("a_valid", {31'd0, a_valid}, {31'd0, m_slot[0].valid});
    check_val("a_pc",    a_pc,    m_slot[0].pc);
    check_val("a_plus",  a_plus,  m_slot[0].pc_plus);
    check_val("a_instr", a_instr, m_slot[0].instr);
    check_val("b_req",   {31'd0, b_req},   {31'd0, exp_req});
    check_val("b_addr",  b_addr,  m_pc[1]);
    check_val("b_valid", {31'd0, b_valid}, {31'd0, m_slot[1].valid});
    check_val("b_pc",    b_pc,    m_slot[1].pc);
    check_val("b_plus",  b_plus,  m_slot[1].pc_plus);
    check_val("b_instr", b_instr, m_slot[1].instr);
    if (phase == 0 && loads == 1 && !d1_done) begin
      d1_done = 1;
      check_val("first_pc",    a_pc,    32'h0000_0000);
      check_val("first_plus",  a_plus,  32'h0000_0004);
      check_val("first_instr", a_instr, W0);
      check_val("wrap_pc",     b_pc,    32'hFFFF_FFFC);
      check_val("wrap_plus",   b_plus,  32'h0000_0000);
    end
    if (phase == 0 && loads == 2 && !d2_done) begin
      d2_done = 1;
      check_val("second_pc",    a_pc,    32'h0000_0004);
      check_val("second_plus",  a_plus,  32'h0000_0008);
      check_val("second_instr", a_instr, W1);
      check_val("wrap2_pc",     b_pc,    32'h0000_0000);
    end
  endtask

  task automatic drive(input int p, input int c);
    int gnt_pct, rdr_pct;
    gnt_pct = (p == 0) ? 100 : (p == 1) ? 30 : 70;
    rdr_pct = (p == 3 || p == 4) ? 10 : (p == 5) ? 5 : 0;
    max_dly = (p == 0) ? 0 : (p == 1) ? 3 : 2;
    reset = (c < 2) || (p == 5 && $urandom_range(0, 99) < 3);
    case (p)
      2:       stall = ((c >> 2) & 1) == 1;
      3, 4, 5: stall = $urandom_range(0, 99) < 20;
      default: stall = 1'b0;
    endcase
    redirect_valid = $urandom_range(0, 99) < rdr_pct;
    redirect_pc    = ($urandom_range(0, 1) == 0) ? 32'h0000_0043 : $urandom;
    case (p)
      4:       flush = redirect_valid || ($urandom_range(0, 99) < 5);
      5:       flush = $urandom_range(0, 99) < 10;
      default: flush = 1'b0;
    endcase
    imem_gnt    = $urandom_range(0, 99) < gnt_pct;
    imem_rvalid = mem_pend && (mem_dly == 0) && !reset;
    if (p == 0 && resps == 0)      imem_rdata = W0;
    else if (p == 0 && resps == 1) imem_rdata = W1;
    else                           imem_rdata = $urandom;
  endtask

  initial begin
    rst_pc[0] = 32'h0000_0000;
    rst_pc[1] = 32'hFFFF_FFFC;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    max_dly = 0; phase = 0; d1_done = 0; d2_done = 0;
    step_model();
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 300; c++) begin
        @(negedge clock);
        check_all();
        phase = p;
        drive(p, c);
        step_model();
      end
    end
    @(negedge clock);
    check_all();
    if (!d1_done || !d2_done) begin
      total++;
      bad++;
      $display("FAIL directed_words: seen1=%0d seen2=%0d required 1 1", d1_done, d2_done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
